fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle decoder/control logic.
- Owns the PC register and issues word requests to instruction memory over a valid/ready request channel with a variable-latency response.
- Presents one instruction at a time to decode, together with its PC and PC+4.
- Advances on a retire acknowledge, using the branch/jump decision (PC_src) and target produced by the execute logic.
- Detects misaligned targets and memory response timeouts, and halts on either.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_unit_if.sv | 12 +
 rtl/fetch_watchdog.sv | 26 ++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    WAIT,
    VALID,
    ERROR
  } state_t;

  localparam logic [1:0]  ERR_NONE     = 2'b00;
  localparam logic [1:0]  ERR_MISALIGN = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'b10;

  localparam logic [31:0] INSTR_BYTES  = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response channel: one word request at a time,
// variable-latency response.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input  ready, rvalid, rdata);
  modport slave  (input  req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_watchdog.sv
// Response watchdog: counts cycles spent waiting for memory and flags the
// cycle in which the count would reach TIMEOUT. TIMEOUT = 0 disables it.
module fetch_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  // Wait-cycle counter, cleared whenever the fetch stage is not waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 8'd1;
  end

  // Expiry is qualified by en, so a response arriving in the same cycle wins.
  assign expired = (TIMEOUT != 0) && en &&
                   (({1'b0, cnt} + 9'd1) == 9'(TIMEOUT));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time from
// instruction memory, holds it for decode until retired, then advances
// sequentially or to the execute-supplied target. Halts on a misaligned
// target or a memory response timeout.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_unit_if.master       imem,
  output logic               instr_valid,
  output logic [31:0]        instr,
  output logic [31:0]        pc_out,
  output logic [31:0]        pc_plus4,
  input  logic               instr_ack,
  input  logic               pc_src,
  input  logic [31:0]        pc_target,
  output logic               fetch_err,
  output logic [1:0]         fetch_err_code
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        req_q;
  logic        wd_clr;
  logic        wd_en;
  logic        wd_expired;

  assign next_pc   = pc_src ? pc_target : pc + INSTR_BYTES;
  assign imem.req  = req_q;
  assign imem.addr = pc;
  assign pc_out    = pc;
  assign pc_plus4  = pc + INSTR_BYTES;

  assign wd_clr = (state != WAIT);
  assign wd_en  = (state == WAIT) && !imem.rvalid;

  fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Fetch FSM with registered request, instruction and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      instr          <= '0;
      instr_valid    <= 1'b0;
      req_q          <= 1'b0;
      fetch_err      <= 1'b0;
      fetch_err_code <= ERR_NONE;
    end else begin
      case (state)
        BOOT: begin
          req_q <= 1'b1;
          state <= FETCH;
        end
        FETCH: begin
          // Address is the PC register, so it stays put until accepted.
          if (imem.ready) begin
            req_q <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem.rvalid) begin
            instr       <= imem.rdata;
            instr_valid <= 1'b1;
            state       <= VALID;
          end else if (wd_expired) begin
            fetch_err      <= 1'b1;
            fetch_err_code <= ERR_TIMEOUT;
            state          <= ERROR;
          end
        end
        VALID: begin
          if (instr_ack) begin
            instr_valid <= 1'b0;
            if (next_pc[1:0] != 2'b00) begin
              // Leave pc pointing at the offending instruction.
              fetch_err      <= 1'b1;
              fetch_err_code <= ERR_MISALIGN;
              state          <= ERROR;
            end else begin
              pc    <= next_pc;
              req_q <= 1'b1;
              state <= FETCH;
            end
          end
        end
        ERROR: begin
          req_q       <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a cycle-stepped memory responder plus a
// PC-level reference model (expected PC, expected word, expected error).
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TMO    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid;
  logic [31:0] instr, pc_out, pc_plus4;
  logic        instr_ack = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] pc_target = '0;
  logic        fetch_err;
  logic [1:0]  fetch_err_code;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] mpc;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem.master),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4),
    .instr_ack      (instr_ack),
    .pc_src         (pc_src),
    .pc_target      (pc_target),
    .fetch_err      (fetch_err),
    .fetch_err_code (fetch_err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Instruction memory contents as seen by the bench.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic noise();
    instr_ack = 1'($urandom_range(0, 1));
    pc_src    = 1'($urandom_range(0, 1));
    pc_target = $urandom;
  endtask

  task automatic quiet();
    instr_ack = 1'b0;
    pc_src    = 1'b0;
    pc_target = '0;
  endtask

  task automatic check_reset_vals();
    chk("rst_req",   32'(imem.req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc",    pc_out, RST_PC);
    chk("rst_err",   32'(fetch_err), 32'd0);
    chk("rst_code",  32'(fetch_err_code), 32'd0);
  endtask

  // Reset, check reset values, release and advance into the first fetch.
  task automatic do_reset();
    quiet();
    imem.ready = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
    rst_n = 1'b0;
    step(); step();
    check_reset_vals();
    rst_n = 1'b1;
    step();
    mpc = RST_PC;
  endtask

  // One full fetch/retire transaction. Entered one tick after the edge that
  // put the DUT in its request phase. err is set if the DUT should now halt.
  task automatic run_instr(input int rdly, input int lat, input int adly,
                           input bit src, input logic [31:0] tgt, output bit err);
    logic [31:0] nxt;
    err = 1'b0;
    chk("req_on", 32'(imem.req), 32'd1);
    chk("req_addr", imem.addr, mpc);
    for (int i = 0; i < rdly; i++) begin
      imem.ready = 1'b0;
      step();
      chk("stall_req", 32'(imem.req), 32'd1);
      chk("stall_addr", imem.addr, mpc);
    end
    imem.ready = 1'b1;
    step();
    imem.ready = 1'b0;
    chk("accept_req_off", 32'(imem.req), 32'd0);
    if (lat > TMO) begin
      for (int i = 0; i < TMO; i++) begin
        noise();
        step();
        if (i < TMO - 1) chk("tmo_early", 32'(fetch_err), 32'd0);
      end
      quiet();
      chk("tmo_err", 32'(fetch_err), 32'd1);
      chk("tmo_code", 32'(fetch_err_code), 32'd2);
      chk("tmo_req", 32'(imem.req), 32'd0);
      chk("tmo_valid", 32'(instr_valid), 32'd0);
      err = 1'b1;
      return;
    end
    for (int i = 0; i < lat - 1; i++) begin
      noise();
      step();
      chk("wait_valid", 32'(instr_valid), 32'd0);
    end
    noise();
    imem.rvalid = 1'b1;
    imem.rdata  = mem_word(mpc);
    step();
    imem.rvalid = 1'b0;
    imem.rdata  = $urandom;
    quiet();
    chk("resp_valid", 32'(instr_valid), 32'd1);
    chk("resp_instr", instr, mem_word(mpc));
    chk("resp_pc", pc_out, mpc);
    chk("resp_pc4", pc_plus4, mpc + 32'd4);
    chk("resp_err", 32'(fetch_err), 32'd0);
    for (int i = 0; i < adly; i++) begin
      pc_src = 1'($urandom_range(0, 1));
      pc_target = $urandom;
      step();
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_pc", pc_out, mpc);
      chk("hold_instr", instr, mem_word(mpc));
    end
    instr_ack = 1'b1; pc_src = src; pc_target = tgt;
    step();
    quiet();
    nxt = src ? tgt : mpc + 32'd4;
    if (nxt[1:0] != 2'b00) begin
      chk("mis_err", 32'(fetch_err), 32'd1);
      chk("mis_code", 32'(fetch_err_code), 32'd1);
      chk("mis_pc", pc_out, mpc);
      chk("mis_req", 32'(imem.req), 32'd0);
      chk("mis_valid", 32'(instr_valid), 32'd0);
      err = 1'b1;
    end else begin
      mpc = nxt;
      chk("ack_valid", 32'(instr_valid), 32'd0);
      chk("ack_req", 32'(imem.req), 32'd1);
      chk("ack_addr", imem.addr, mpc);
    end
  endtask

  // After a halt, the stage must ignore all inputs.
  task automatic check_halt(input logic [1:0] code, input logic [31:0] pc);
    for (int i = 0; i < 4; i++) begin
      noise();
      imem.ready = 1'($urandom_range(0, 1));
      step();
      chk("halt_err", 32'(fetch_err), 32'd1);
      chk("halt_code", 32'(fetch_err_code), 32'(code));
      chk("halt_req", 32'(imem.req), 32'd0);
      chk("halt_valid", 32'(instr_valid), 32'd0);
      chk("halt_pc", pc_out, pc);
    end
    quiet();
    imem.ready = 1'b0;
  endtask

  initial begin
    bit e;
    int c0;
    logic [31:0] t;

    imem.ready = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
    do_reset();

    // First fetch at minimum latency, then three sequential retires.
    c0 = cyc;
    run_instr(0, 1, 0, 1'b0, 32'h0, e);
    run_instr(0, 1, 0, 1'b0, 32'h0, e);
    run_instr(0, 1, 0, 1'b0, 32'h0, e);
    chk("seq_pc", mpc, 32'hC);
    chk("throughput", 32'(cyc - c0), 32'd9);

    // Taken branch, stalled request, then wrap at the top of the space.
    run_instr(0, 2, 1, 1'b1, 32'h40, e);
    chk("branch_addr", imem.addr, 32'h40);
    run_instr(5, 1, 0, 1'b1, 32'hFFFF_FFFC, e);
    run_instr(0, TMO, 0, 1'b0, 32'h0, e);
    chk("wrap_addr", imem.addr, 32'h0);

    // Randomized aligned traffic with response latency up to the limit.
    for (int n = 0; n < 60; n++) begin
      t = $urandom & 32'hFFFF_FFFC;
      run_instr($urandom_range(0, 3), $urandom_range(1, TMO), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), t, e);
    end

    // Misaligned jump target halts with pc unchanged.
    run_instr(0, 1, 0, 1'b1, 32'h40, e);
    run_instr(1, 1, 0, 1'b1, 32'h42, e);
    chk("mis_halted", 32'(e), 32'd1);
    check_halt(2'b01, 32'h40);

    // Response never arrives: watchdog halt.
    do_reset();
    run_instr(0, TMO + 1, 0, 1'b0, 32'h0, e);
    chk("tmo_halted", 32'(e), 32'd1);
    check_halt(2'b10, RST_PC);

    // Reset asserted mid-wait takes effect without a clock edge.
    do_reset();
    run_instr(0, 1, 0, 1'b1, 32'h80, e);
    imem.ready = 1'b1;
    step();
    imem.ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    step();
    rst_n = 1'b1;
    step();
    mpc = RST_PC;
    run_instr(0, 1, 0, 1'b0, 32'h0, e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
